// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: transfer sizes, FSM states
// and the byte count helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Encoding 11 is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. req[0] = fetch, req[1] = data.
// The pointer only moves on a tie, toward the port that lost.
module rr_arb2 #(
    parameter logic RR_INIT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_ptr;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= RR_INIT;
        end else if (advance && (req == 2'b11)) begin
            r_ptr <= grant[0];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide RAM between the fetch and load/store ports, running each
// request as 1/2/4 little-endian byte cycles and returning a one-cycle ack.
//
//  state | meaning
//  IDLE  | sample requests, latch the granted one
//  XFER  | one RAM byte cycle per clock (address = base + k)
//  DRAIN | capture the last read byte from the registered RAM output
//  RESP  | ack pulse on the granted port
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int   ADDR_W  = 12,
    parameter logic RR_INIT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              ram_r_wn,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data_in,
    input  logic [7:0]        ram_data_out
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic        r_port;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;

    logic [1:0]  w_grant;
    logic [2:0]  w_nbytes;
    logic        w_last;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_asm;

    rr_arb2 #(
        .RR_INIT (RR_INIT)
    ) u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({d_req, if_req}),
        .advance (r_state == IDLE),
        .grant   (w_grant)
    );

    assign w_nbytes = size_bytes(r_size);
    assign w_last   = (r_cnt == (w_nbytes - 3'd1));

    // RAM output lags the address by one cycle, so XFER captures the previous byte.
    always_comb begin
        w_cap_idx = (r_state == DRAIN) ? r_cnt[1:0] : (r_cnt[1:0] - 2'd1);
        w_asm     = r_asm;
        w_asm[{w_cap_idx, 3'b000} +: 8] = ram_data_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_r_wn    = 1'b1;
        case (r_state)
            IDLE: begin
                if (|w_grant) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                ram_r_wn = ~r_we;
                if (w_last) begin
                    w_state_nxt = r_we ? RESP : DRAIN;
                end
            end
            DRAIN: w_state_nxt = RESP;
            RESP:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            r_port      <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= SZ_WORD;
            r_wdata     <= 32'd0;
            r_asm       <= 32'd0;
            ram_address <= '0;
            ram_data_in <= 8'd0;
            if_rdata    <= 32'd0;
            d_rdata     <= 32'd0;
            if_ack      <= 1'b0;
            d_ack       <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_port      <= w_grant[1];
                        r_we        <= w_grant[1] & d_we;
                        r_size      <= w_grant[1] ? d_size : SZ_WORD;
                        r_wdata     <= d_wdata;
                        ram_data_in <= d_wdata[7:0];
                        ram_address <= w_grant[1] ? d_addr : if_addr;
                        r_cnt       <= 3'd0;
                        r_asm       <= 32'd0;
                    end
                end
                XFER: begin
                    ram_address <= ram_address + 1'b1;
                    r_wdata     <= r_wdata >> 8;
                    ram_data_in <= r_wdata[15:8];
                    if (!r_we && (r_cnt != 3'd0)) begin
                        r_asm <= w_asm;
                    end
                    if (!w_last) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else if (r_we) begin
                        d_ack <= 1'b1;
                    end
                end
                DRAIN: begin
                    r_asm <= w_asm;
                    if (r_port) begin
                        d_rdata <= w_asm;
                        d_ack   <= 1'b1;
                    end else begin
                        if_rdata <= w_asm;
                        if_ack   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural registered RAM and a
// byte-array reference model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [11:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        ram_r_wn;
    logic [11:0] ram_address;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out = 8'h00;

    logic [7:0]  ram     [4096];
    logic [7:0]  ref_mem [4096];
    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        mon_en  = 1'b0;
    logic        prev_if = 1'b0;
    logic        prev_d  = 1'b0;

    mem_port_arbiter #(.ADDR_W(12), .RR_INIT(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ack       (if_ack),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_size       (d_size),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_ack        (d_ack),
        .ram_r_wn     (ram_r_wn),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        if (i >= 'h10 && i <= 'h13) return 8'(8'h11 * (i - 'h0F));
        if (i == 'h20) return 8'h80;
        return 8'((i * 37 + 5) & 255);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [11:0] a, input logic [1:0] sz);
        logic [31:0] v = 32'd0;
        logic [11:0] ak;
        for (int k = 0; k < nbytes(sz); k++) begin
            ak = a + 12'(k);
            v[8*k +: 8] = ref_mem[ak];
        end
        return v;
    endfunction

    // Registered-output RAM: writes on every edge while ram_r_wn is low.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (!ram_r_wn) ram[ram_address] <= ram_data_in;
            ram_data_out <= ram[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && (if_ack || d_ack)) begin
            exp_t e;
            chk("both_ack", {31'd0, if_ack & d_ack}, 32'd0);
            if (if_ack) chk("if_pulse", {31'd0, prev_if}, 32'd0);
            if (d_ack)  chk("d_pulse",  {31'd0, prev_d},  32'd0);
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                if (e.port) chk("d_rdata", d_rdata, e.data);
                else        chk("if_rdata", if_rdata, e.data);
            end
        end
        prev_if <= if_ack;
        prev_d  <= d_ack;
    end

    task automatic chk_reset();
        chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
        chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_addr", {20'd0, ram_address}, 32'd0);
        chk("rst_din", {24'd0, ram_data_in}, 32'd0);
        chk("rst_rwn", {31'd0, ram_r_wn}, 32'd1);
    endtask

    // One transfer on an idle arbiter; checks accept-to-ack latency.
    task automatic do_xfer(input logic is_d, input logic we, input logic [1:0] sz,
                           input logic [11:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n = 0;
        logic        got = 1'b0;
        logic        rwn_low = 1'b0;
        logic [11:0] ak;
        int          lat = we ? nbytes(sz) : nbytes(sz) + 1;
        if (!is_d) lat = 5;
        e.port = is_d;
        e.data = 32'd0;
        if (is_d && we) begin
            for (int k = 0; k < nbytes(sz); k++) begin
                ak = a + 12'(k);
                ref_mem[ak] = wd[8*k +: 8];
            end
            e.data = d_rdata;
        end else begin
            e.data = model_load(a, is_d ? sz : SZ_WORD);
        end
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        // Store acks leave d_rdata untouched, so the expectation is its held value.
        if (is_d && we) e.data = d_rdata;
        exp_q.push_back(e);
        @(posedge clk);
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!ram_r_wn) rwn_low = 1'b1;
            got = is_d ? d_ack : if_ack;
        end
        chk(is_d ? "d_latency" : "if_latency", n, got ? lat : -1);
        if (!we) chk("read_rwn", {31'd0, rwn_low}, 32'd0);
        if (is_d) d_req = 1'b0;
        else      if_req = 1'b0;
    endtask

    task automatic port_proc(input logic is_d, input logic [11:0] a0, input logic [11:0] a1);
        logic got;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (is_d) begin
                d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = (i == 0) ? a0 : a1;
            end else begin
                if_req = 1'b1; if_addr = (i == 0) ? a0 : a1;
            end
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                got = is_d ? d_ack : if_ack;
            end
            chk(is_d ? "d_tmo" : "if_tmo", {31'd0, got}, 32'd1);
            if (is_d) d_req = 1'b0;
            else      if_req = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        logic [7:0] b202, b203;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1; if_req = 1'b0; if_addr = 12'd0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_addr = 12'd0; d_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);
        chk_reset();
        mon_en = 1'b1;

        do_xfer(1'b0, 1'b0, SZ_WORD, 12'h010, 32'd0);
        chk("t1_const", if_rdata, 32'h4433_2211);

        do_xfer(1'b1, 1'b1, SZ_WORD, 12'h100, 32'hDEAD_BEEF);
        do_xfer(1'b1, 1'b0, SZ_HALF, 12'h102, 32'd0);
        chk("t2_const", d_rdata, 32'h0000_DEAD);

        do_xfer(1'b1, 1'b0, SZ_BYTE, 12'h020, 32'd0);
        chk("t6_const", d_rdata, 32'h0000_0080);

        // Tie on every IDLE edge: data wins first, then grants alternate.
        e.port = 1'b1; e.data = model_load(12'h100, SZ_WORD); exp_q.push_back(e);
        e.port = 1'b0; e.data = model_load(12'h010, SZ_WORD); exp_q.push_back(e);
        e.port = 1'b1; e.data = model_load(12'h020, SZ_WORD); exp_q.push_back(e);
        e.port = 1'b0; e.data = model_load(12'h014, SZ_WORD); exp_q.push_back(e);
        fork
            port_proc(1'b1, 12'h100, 12'h020);
            port_proc(1'b0, 12'h010, 12'h014);
        join
        repeat (2) @(negedge clk);

        do_xfer(1'b1, 1'b1, SZ_WORD, 12'hFFE, 32'h0403_0201);
        do_xfer(1'b1, 1'b0, SZ_WORD, 12'hFFE, 32'd0);
        chk("t4_const", d_rdata, 32'h0403_0201);
        do_xfer(1'b1, 1'b0, SZ_HALF, 12'h000, 32'd0);
        chk("t4_wrap", d_rdata, 32'h0000_0403);

        b202 = ref_mem[12'h202];
        b203 = ref_mem[12'h203];
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = SZ_WORD; d_addr = 12'h200; d_wdata = 32'hAABB_CCDD;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t5_writing", {31'd0, ram_r_wn}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t5_rwn", {31'd0, ram_r_wn}, 32'd1);
        chk("t5_noack", {31'd0, d_ack}, 32'd0);
        d_req = 1'b0;
        ref_mem[12'h200] = 8'hDD;
        ref_mem[12'h201] = 8'hCC;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        do_xfer(1'b1, 1'b0, SZ_WORD, 12'h200, 32'd0);
        chk("t5_partial", d_rdata, {b203, b202, 16'hCCDD});

        for (int i = 0; i < 12; i++) begin
            logic is_d = 1'($urandom_range(0, 1));
            do_xfer(is_d, is_d & 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    12'($urandom_range(0, 4095)), $urandom);
        end

        repeat (3) @(negedge clk);
        chk("sb_left", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
